// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mult_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One recoded radix-4 Booth digit in {-2,-1,0,+1,+2}
    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    // Number of Booth iterations for an NB-bit operand extended to NB+2 bits
    function automatic int iter_count(input int nb);
        return nb / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: window {b[i+1], b[i], b[i-1]} -> digit flags.
module booth_r4_enc (
    input  logic [2:0] i_win,
    output logic       o_neg,
    output logic       o_two,
    output logic       o_zero
);

    // 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
    always_comb begin
        o_zero = (i_win == 3'b000) || (i_win == 3'b111);
        o_two  = (i_win == 3'b011) || (i_win == 3'b100);
        o_neg  = i_win[2] && !(i_win[1] && i_win[0]);
    end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned NB x NB -> 2*NB.
// Optional macro SEQ_MULT_ACCUMULATE_EN adds an 'acc' input that adds the
// new product to the previous Product instead of overwriting it.
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int NB = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_mode,
    input  logic [NB-1:0]   A,
    input  logic [NB-1:0]   B,
`ifdef SEQ_MULT_ACCUMULATE_EN
    input  logic            acc,
`endif
    output logic [2*NB-1:0] Product,
    output logic            ready,
    output logic            done
);

    localparam int NITER = iter_count(NB);
    localparam int CW    = $clog2(NITER + 1);
    localparam int XW    = NB + 2;   // extended operand width
    localparam int UW    = NB + 4;   // upper accumulator: headroom for +-2*A sums

    state_t             r_state;
    state_t             w_state_nxt;
    logic [XW-1:0]      r_a;
    logic [XW-1:0]      r_mq;
    logic [UW-1:0]      r_acc;
    logic               r_prev;
    logic [CW-1:0]      r_cnt;
    logic [2*NB-1:0]    r_prod;
`ifdef SEQ_MULT_ACCUMULATE_EN
    logic               r_acc_en;
`endif

    logic               w_start_ok;
    logic               w_last;
    booth_digit_t       w_dig;
    logic [UW-1:0]      w_a_ext;
    logic [UW-1:0]      w_mag;
    logic [UW-1:0]      w_addend;
    logic [UW-1:0]      w_sum;
    logic [UW+XW-1:0]   w_shift;
    logic [2*NB-1:0]    w_res;
    logic [XW-1:0]      w_a_in;
    logic [XW-1:0]      w_b_in;

    assign w_start_ok = start && (r_state != RUN);
    assign w_last     = (r_state == RUN) && (r_cnt == CW'(1));

    // Operand extension: sign bit replicated only in two's complement mode
    assign w_a_in = {{2{signed_mode & A[NB-1]}}, A};
    assign w_b_in = {{2{signed_mode & B[NB-1]}}, B};

    booth_r4_enc u_enc (
        .i_win  ({r_mq[1:0], r_prev}),
        .o_neg  (w_dig.neg),
        .o_two  (w_dig.two),
        .o_zero (w_dig.zero)
    );

    // Booth step: add digit*A to the upper half, then shift {acc, mq} right by 2
    always_comb begin
        w_a_ext  = {{(UW-XW){r_a[XW-1]}}, r_a};
        w_mag    = w_dig.two ? (w_a_ext << 1) : w_a_ext;
        w_addend = w_dig.zero ? '0 : (w_dig.neg ? (~w_mag + UW'(1)) : w_mag);
        w_sum    = r_acc + w_addend;
        w_shift  = $signed({w_sum, r_mq}) >>> 2;
        w_res    = w_shift[2*NB-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture on accepted start, one Booth step per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_mq     <= '0;
            r_acc    <= '0;
            r_prev   <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
`ifdef SEQ_MULT_ACCUMULATE_EN
            r_acc_en <= 1'b0;
`endif
        end else if (w_start_ok) begin
            r_a      <= w_a_in;
            r_mq     <= w_b_in;
            r_acc    <= '0;
            r_prev   <= 1'b0;
            r_cnt    <= CW'(NITER);
`ifdef SEQ_MULT_ACCUMULATE_EN
            r_acc_en <= acc;
`endif
        end else if (r_state == RUN) begin
            r_acc  <= w_shift[UW+XW-1:XW];
            r_mq   <= w_shift[XW-1:0];
            r_prev <= r_mq[1];
            r_cnt  <= r_cnt - CW'(1);
            // Product changes only when the final step completes
            if (w_last) begin
`ifdef SEQ_MULT_ACCUMULATE_EN
                r_prod <= r_acc_en ? (r_prod + w_res) : w_res;
`else
                r_prod <= w_res;
`endif
            end
        end
    end

    assign Product = r_prod;
    assign ready   = (r_state != RUN);
    assign done    = (r_state == DONE);

endmodule

// File: tb/tb_seq_booth_mult.sv
// Self-checking bench for seq_booth_mult: directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_seq_booth_mult;

    localparam int NB  = 8;
    localparam int LAT = NB / 2 + 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic            signed_mode;
    logic [NB-1:0]   A;
    logic [NB-1:0]   B;
    logic [2*NB-1:0] Product;
    logic            ready;
    logic            done;
`ifdef SEQ_MULT_ACCUMULATE_EN
    logic            acc;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*NB-1:0] model_prod;

    seq_booth_mult #(.NB(NB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
`ifdef SEQ_MULT_ACCUMULATE_EN
        .acc         (acc),
`endif
        .Product     (Product),
        .ready       (ready),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected end before 2ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Exact product by plain integer arithmetic, truncated to 2*NB bits
    function automatic logic [2*NB-1:0] ref_mul(input logic sm, input logic [NB-1:0] a,
                                                input logic [NB-1:0] b);
        longint x, y;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        return (2*NB)'(x * y);
    endfunction

    // Issue one operation, wait for done, report Product and edges-to-done
    task automatic run_op(input logic sm, input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic ac, output logic [2*NB-1:0] p, output int lat);
        @(negedge clk);
        start = 1'b1; signed_mode = sm; A = a; B = b;
`ifdef SEQ_MULT_ACCUMULATE_EN
        acc = ac;
`endif
        @(posedge clk); #1;
        chk("ready_low_in_run", ready, 1'b0);
        // scramble inputs: captured operands must not follow them
        start = 1'b0; A = NB'($urandom); B = NB'($urandom); signed_mode = ~sm;
`ifdef SEQ_MULT_ACCUMULATE_EN
        acc = ~ac;
`endif
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk("ready_in_done", ready, 1'b1);
        p = Product;
    endtask

    // Expected Product after an op, given model state and accumulate request
    function automatic logic [2*NB-1:0] expect_prod(input logic sm, input logic [NB-1:0] a,
                                                    input logic [NB-1:0] b, input logic ac);
        logic [2*NB-1:0] m;
        m = ref_mul(sm, a, b);
`ifdef SEQ_MULT_ACCUMULATE_EN
        if (ac) m = model_prod + m;
`else
        if (ac) m = m;
`endif
        return m;
    endfunction

    typedef struct {
        logic            sm;
        logic [NB-1:0]   a;
        logic [NB-1:0]   b;
        logic [2*NB-1:0] exp;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [2*NB-1:0] p;
        logic [2*NB-1:0] e;
        int lat;
        int pulses;
        int gap;
        logic sm, ac;
        logic [NB-1:0] ra, rb;

        vt[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vt[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vt[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vt[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vt[4] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vt[5] = '{1'b0, 8'h7F, 8'h7F, 16'h3F01};
        vt[6] = '{1'b0, 8'h00, 8'hAB, 16'h0000};

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
`ifdef SEQ_MULT_ACCUMULATE_EN
        acc = 1'b0;
`endif
        model_prod = '0;
        #13;
        chk("reset_product", Product, 16'h0000);
        chk("reset_ready", ready, 1'b1);
        chk("reset_done", done, 1'b0);
        @(negedge clk); rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].sm, vt[i].a, vt[i].b, 1'b0, p, lat);
            chk($sformatf("table%0d_product", i), p, vt[i].exp);
            chk($sformatf("table%0d_latency", i), lat, LAT);
            model_prod = vt[i].exp;
        end

        // Second start while running is ignored; one done pulse
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; A = 8'd2; B = 8'd3;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b1; A = 8'd7; B = 8'd7;
        @(posedge clk); #1 start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("ignored_start_product", Product, 16'h0006);
        chk("ignored_start_done_pulses", pulses, 1);
        model_prod = 16'h0006;

        // Reset during the third RUN cycle
        @(negedge clk);
        start = 1'b1; A = 8'd9; B = 8'd9;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("midrun_reset_product", Product, 16'h0000);
        chk("midrun_reset_ready", ready, 1'b1);
        chk("midrun_reset_done", done, 1'b0);
        @(negedge clk); rst = 1'b0;
        model_prod = '0;
        run_op(1'b0, 8'd4, 8'd4, 1'b0, p, lat);
        chk("after_reset_product", p, 16'h0010);
        chk("after_reset_latency", lat, LAT);
        model_prod = p;

`ifdef SEQ_MULT_ACCUMULATE_EN
        // Accumulate, issued back-to-back from DONE
        run_op(1'b0, 8'd3, 8'd4, 1'b0, p, lat);
        chk("acc_first_product", p, 16'h000C);
        chk("acc_first_latency", lat, LAT);
        run_op(1'b0, 8'd5, 8'd6, 1'b1, p, lat);
        chk("acc_second_product", p, 16'h002A);
        chk("acc_second_latency", lat, LAT);
        model_prod = p;
`endif

        // Random operations with random gaps (gap 0 = back-to-back)
        for (int i = 0; i < 60; i++) begin
            sm = 1'($urandom);
            ra = NB'($urandom);
            rb = NB'($urandom);
            ac = 1'($urandom);
            e  = expect_prod(sm, ra, rb, ac);
            run_op(sm, ra, rb, ac, p, lat);
            chk($sformatf("rand%0d_product", i), p, e);
            chk($sformatf("rand%0d_latency", i), lat, LAT);
            model_prod = p;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                chk($sformatf("rand%0d_done_one_cycle", i), done, 1'b0);
                chk($sformatf("rand%0d_product_hold", i), Product, e);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
